// File: rtl/genius_game_ctrl.sv
// rtl/genius_game_ctrl.sv - memory-game sequencer: grows, shows and checks a colour sequence
//
// Ports:
//   clk, rst_n                      clock and synchronous active-low reset
//   start_i, difficulty_i           start/restart request, max length select (4/8/16/32)
//   lfsr_i                          free-running random value, low bits become the new colour
//   player_valid_i, player_color_i  one-cycle button strobe and pressed colour
//   mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i   external sequence memory (async read)
//   show_valid_o, show_color_o      display LED enable and colour
//   state_o, level_o, victory_o, defeat_o            status
module genius_game_ctrl #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 2,
    parameter int LFSR_WIDTH     = 16,
    parameter int SHOW_CYCLES    = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [1:0]            difficulty_i,
    input  logic [LFSR_WIDTH-1:0] lfsr_i,
    input  logic                  player_valid_i,
    input  logic [DATA_WIDTH-1:0] player_color_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  show_valid_o,
    output logic [DATA_WIDTH-1:0] show_color_o,
    output logic [7:0]            state_o,
    output logic [5:0]            level_o,
    output logic                  victory_o,
    output logic                  defeat_o
);

    typedef enum logic [7:0] {
        IDLE                   = 8'd0,
        GET_NEXT_SEQUENCE_ITEM = 8'd1,
        SHOW_SEQUENCE          = 8'd2,
        GET_PLAYER_INPUT       = 8'd3,
        COMPARISON             = 8'd4,
        DEFEAT                 = 8'd5,
        EVALUATE               = 8'd6,
        VICTORY                = 8'd7
    } state_t;

    // phase runs 0..SHOW+GAP-1 per displayed colour; LED is lit for the low SHOW_CYCLES values
    localparam logic [8:0]  SHOW_END     = 9'(SHOW_CYCLES);
    localparam logic [8:0]  PHASE_LAST   = 9'(SHOW_CYCLES + GAP_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                state;
    logic [5:0]            level;
    logic [5:0]            max_len;
    logic [ADDR_WIDTH-1:0] idx;
    logic [8:0]            phase;
    logic [15:0]           timer;
    logic [DATA_WIDTH-1:0] pressed;
    logic                  last_idx;
    logic                  lfsr_unused;

    function automatic logic [5:0] len_of(input logic [1:0] sel);
        case (sel)
            2'b00:   return 6'd4;
            2'b01:   return 6'd8;
            2'b10:   return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

    assign last_idx    = (6'(idx) == level - 6'd1);
    assign lfsr_unused = ^lfsr_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            level   <= 6'd0;
            max_len <= 6'd4;
            idx     <= '0;
            phase   <= 9'd0;
            timer   <= 16'd0;
            pressed <= '0;
        end else begin
            case (state)
                IDLE, VICTORY, DEFEAT: begin
                    if (start_i) begin
                        max_len <= len_of(difficulty_i);
                        level   <= 6'd0;
                        state   <= GET_NEXT_SEQUENCE_ITEM;
                    end
                end
                GET_NEXT_SEQUENCE_ITEM: begin
                    level <= level + 6'd1;
                    idx   <= '0;
                    phase <= 9'd0;
                    state <= SHOW_SEQUENCE;
                end
                SHOW_SEQUENCE: begin
                    if (phase == PHASE_LAST) begin
                        phase <= 9'd0;
                        if (last_idx) begin
                            idx   <= '0;
                            timer <= 16'd0;
                            state <= GET_PLAYER_INPUT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        phase <= phase + 9'd1;
                    end
                end
                GET_PLAYER_INPUT: begin
                    // a press wins over a timeout landing in the same cycle
                    if (player_valid_i) begin
                        pressed <= player_color_i;
                        state   <= COMPARISON;
                    end else if (timer == TIMEOUT_LAST) begin
                        state <= DEFEAT;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                COMPARISON: begin
                    if (pressed != mem_rdata_i) begin
                        state <= DEFEAT;
                    end else if (last_idx) begin
                        state <= EVALUATE;
                    end else begin
                        idx   <= idx + 1'b1;
                        timer <= 16'd0;
                        state <= GET_PLAYER_INPUT;
                    end
                end
                EVALUATE: begin
                    state <= (level == max_len) ? VICTORY : GET_NEXT_SEQUENCE_ITEM;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr_o = '0;
        case (state)
            GET_NEXT_SEQUENCE_ITEM:                       mem_addr_o = ADDR_WIDTH'(level);
            SHOW_SEQUENCE, GET_PLAYER_INPUT, COMPARISON:  mem_addr_o = idx;
            default:                                      mem_addr_o = '0;
        endcase
    end

    assign mem_we_o     = (state == GET_NEXT_SEQUENCE_ITEM);
    assign mem_wdata_o  = mem_we_o ? lfsr_i[DATA_WIDTH-1:0] : '0;
    assign show_valid_o = (state == SHOW_SEQUENCE) && (phase < SHOW_END);
    assign show_color_o = show_valid_o ? mem_rdata_i : '0;
    assign state_o      = state;
    assign level_o      = level;
    assign victory_o    = (state == VICTORY);
    assign defeat_o     = (state == DEFEAT);

endmodule
